alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//   Parametrised multi-cycle ALU for the MIPS datapath.
//   - Keeps the existing single-cycle ops: AND, OR, ADD, SUB, SLT.
//   - Adds iterative unsigned multiply and divide with a HI result word.
//   - Uses valid/ready handshakes on both input and output, so the controller can stall.
//   - Sits in the execute stage; the multi-cycle unit replaces the combinational ALU there.
// PARAMETERS
//   WIDTH      32   operand/result width in bits; must be >= 4
//   CNT_W      $clog2(WIDTH+1)   iteration-counter width (derived, do not override)
// PORTS
//   clk        in   1      rising-edge clock; single clock domain
//   reset      in   1      asynchronous, active-high reset
//   in_valid   in   1      operands and op presented
//   in_ready   out  1      block can accept an op this cycle
//   a, b       in   WIDTH  operands
//   f          in   4      op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT,
//                          1000 MULTU, 1001 DIVU; all other codes are reserved
//   out_valid  out  1      result words valid
//   out_ready  in   1      consumer takes the result this cycle
//   y          out  WIDTH  result; low product for MULTU, quotient for DIVU
//   hi         out  WIDTH  high product for MULTU, remainder for DIVU; 0 for every other op
//   zero       out  1      (y == 0), registered together with y
// BEHAVIOUR
//   - Reset: state IDLE; in_ready=1; out_valid=0; y=0; hi=0; zero=1; counter and working registers 0.
//   - Accept: when in_valid & in_ready, latch a, b and f.
//   - FSM states: IDLE, BUSY, DONE.
//     - IDLE -> DONE  on accepting a single-cycle op or a reserved code.
//     - IDLE -> BUSY  on accepting MULTU or DIVU.
//     - BUSY -> DONE  when the counter reaches WIDTH.
//     - DONE -> IDLE  when out_ready=1.
//   - in_ready = (state==IDLE). No accept happens in BUSY or DONE, so accept and drain never coincide.
//   - Latency, counted from the accept edge to out_valid:
//     - single-cycle ops: 1 cycle
//     - MULTU/DIVU: WIDTH+1 cycles (one iteration per cycle)
//   - out_valid = (state==DONE). y, hi and zero stay stable while out_valid=1 and out_ready=0.
//   - Single-cycle arithmetic:
//     - b2 = f[2] ? ~b : b; sum = a + b2 + f[2], mod 2^WIDTH.
//     - SLT returns sum[WIDTH-1], zero-extended. Overflow is ignored; this matches the existing ALU semantics.
//   - MULTU: shift-add, LSB first. The 2*WIDTH-bit product is {hi, y}.
//   - DIVU: restoring divide, one quotient bit per cycle.
//     - y = a / b, hi = a % b.
//     - Divide by zero: y = all ones, hi = a. No trap.
//   - Reserved codes: y=0, hi=0, zero=1, with 1-cycle latency.
//   - Reset asserted mid-operation aborts the op. All state returns to reset values on the next evaluation (asynchronous), and no partial result is ever presented.
//   - Inputs are ignored outside IDLE. Changing a, b or f while BUSY has no effect.
// STRUCTURE
//   - alu_pkg (shared package):
//     - typedef enum logic [3:0] alu_op_t for the op codes above
//     - typedef enum logic [1:0] alu_state_t {IDLE, BUSY, DONE}
//   - Sub-module alu_core: combinational WIDTH-parametrised AND/OR/ADD/SUB/SLT datapath.
//     Instanced once and reused by DIVU for the trial subtract.
//   - Top: FSM, counter, and the multiply/divide shift registers.
// TESTING
//   1. ADD a=5, b=-3 (WIDTH=32) -> 1 cycle after accept: out_valid=1, y=2, hi=0, zero=0.
//   2. SUB a=7, b=7 -> y=0, zero=1. SLT a=-1, b=1 -> y=1.
//   3. MULTU a=0xFFFFFFFF, b=2 -> out_valid at accept+33: hi=1, y=0xFFFFFFFE. in_ready=0 throughout.
//   4. DIVU a=100, b=7 -> y=14, hi=2. DIVU a=9, b=0 -> y=0xFFFFFFFF, hi=9.
//   5. Backpressure: hold out_ready=0 for 5 cycles after DONE.
//      -> y/hi/zero stable, in_ready=0, in_valid ignored; after out_ready=1 -> IDLE the next cycle.
//   6. Assert reset 10 cycles into a MULTU.
//      -> out_valid=0, in_ready=1, y=0 immediately; the next op completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for the multi-cycle MIPS ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_MULTU = 4'b1000,
    OP_DIVU  = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // Low three function bits that make the core subtract (b inverted, carry-in 1).
  localparam logic [2:0] CORE_SUB = 3'b110;

  // True for the ops the combinational core finishes in one cycle.
  function automatic logic is_single_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational AND/OR/ADD/SUB/SLT datapath. The carry out lets the
// divider use the same adder for its trial subtract.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  logic [WIDTH-1:0] b2;
  logic [WIDTH-1:0] sum;

  // Shared adder; f[2] turns it into a subtractor, f[1:0] picks the result.
  always_comb begin
    b2          = f[2] ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, b2} + {{WIDTH{1'b0}}, f[2]};
    y           = '0;
    case (f[1:0])
      2'b00: y = a & b2;
      2'b01: y = a | b2;
      2'b10: y = sum;
      2'b11: y = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned
// multiply and divide, with valid/ready handshakes on both sides.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  alu_state_t       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             is_mul_q, is_mul_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;   // multiplicand or divisor
  logic [WIDTH-1:0] whi_q,    whi_d;     // product high half / partial remainder
  logic [WIDTH-1:0] wlo_q,    wlo_d;     // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0] y_q,      y_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic             zero_q,   zero_d;

  logic [WIDTH-1:0] core_a, core_b, core_y;
  logic [2:0]       core_f;
  logic             core_cout;
  logic [WIDTH-1:0] div_low;
  logic             div_take;
  logic [WIDTH:0]   mul_sum;
  logic [CNT_W-1:0] cnt_nxt;

  // Remainder shifted left with the next dividend bit; its top bit falls
  // out of the WIDTH-bit core and is folded back in through div_take.
  assign div_low  = {whi_q[WIDTH-2:0], wlo_q[WIDTH-1]};
  assign div_take = whi_q[WIDTH-1] | core_cout;
  assign mul_sum  = {1'b0, whi_q} + (wlo_q[0] ? {1'b0, mcand_q} : '0);
  assign cnt_nxt  = cnt_q + 1'b1;

  // Core sees the live operands when idle, the trial subtract otherwise.
  always_comb begin
    core_a = div_low;
    core_b = mcand_q;
    core_f = CORE_SUB;
    if (state_q == IDLE) begin
      core_a = a;
      core_b = b;
      core_f = f[2:0];
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a    (core_a),
    .b    (core_b),
    .f    (core_f),
    .y    (core_y),
    .cout (core_cout)
  );

  // Next-state logic: accept, iterate one bit per cycle, hold until drained.
  // NOTE: every _d starts from its _q so no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    mcand_d  = mcand_q;
    whi_d    = whi_q;
    wlo_d    = wlo_q;
    y_d      = y_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          whi_d = '0;
          if (f == OP_MULTU) begin
            is_mul_d = 1'b1;
            mcand_d  = a;
            wlo_d    = b;
            state_d  = BUSY;
          end else if (f == OP_DIVU) begin
            is_mul_d = 1'b0;
            mcand_d  = b;
            wlo_d    = a;
            state_d  = BUSY;
          end else begin
            y_d     = is_single_op(f) ? core_y : '0;
            hi_d    = '0;
            zero_d  = (y_d == '0);
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_nxt;
        if (is_mul_q) begin
          {whi_d, wlo_d} = {mul_sum, wlo_q[WIDTH-1:1]};
        end else begin
          whi_d = div_take ? core_y : div_low;
          wlo_d = {wlo_q[WIDTH-2:0], div_take};
        end
        // Results are published only on the final iteration.
        if (cnt_nxt == CNT_LAST) begin
          y_d     = wlo_d;
          hi_d    = whi_d;
          zero_d  = (wlo_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous abort.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      mcand_q  <= '0;
      whi_q    <= '0;
      wlo_q    <= '0;
      y_q      <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
      mcand_q  <= mcand_d;
      whi_q    <= whi_d;
      wlo_q    <= wlo_d;
      y_q      <= y_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign hi        = hi_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vectors with literal expectations,
// plus an arithmetic reference model checked on every clock.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  a         = '0;
  logic [W-1:0]  b         = '0;
  logic [3:0]    f         = '0;
  logic          in_ready, out_valid, zero;
  logic [W-1:0]  y, hi;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .f         (f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .hi        (hi),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the result words and latency must be for one op.
  function automatic void model(input logic [W-1:0] ma, mb, input logic [3:0] mf,
                                output logic [W-1:0] my, mhi, output int lat);
    logic [2*W-1:0] p;
    logic [W-1:0]   d;
    my  = '0;
    mhi = '0;
    lat = 1;
    case (mf)
      4'b0000: my = ma & mb;
      4'b0001: my = ma | mb;
      4'b0010: my = ma + mb;
      4'b0110: my = ma - mb;
      4'b0111: begin d = ma - mb; my = {{(W-1){1'b0}}, d[W-1]}; end
      4'b1000: begin
        p   = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
        my  = p[W-1:0];
        mhi = p[2*W-1:W];
        lat = W + 1;
      end
      4'b1001: begin
        lat = W + 1;
        if (mb == '0) begin my = '1; mhi = ma; end
        else begin my = ma / mb; mhi = ma % mb; end
      end
      default: ;
    endcase
  endfunction

  // Scoreboard: one outstanding op at most.
  logic         pending = 1'b0;
  int           edge_n  = 0;
  int           exp_due = 0;
  int           mlat;
  logic [W-1:0] exp_y   = '0;
  logic [W-1:0] exp_hi  = '0;
  logic         ev;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pending = 1'b0;
    end else begin
      edge_n++;
      if (pending && out_valid && out_ready) pending = 1'b0;
      if (in_valid && in_ready) begin
        model(a, b, f, exp_y, exp_hi, mlat);
        pending = 1'b1;
        exp_due = edge_n + mlat - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready",  in_ready,  1'b1);
      check("rst_y",         y,         '0);
      check("rst_hi",        hi,        '0);
      check("rst_zero",      zero,      1'b1);
    end else begin
      ev = pending && (edge_n >= exp_due);
      check("mdl_out_valid", out_valid, ev);
      check("mdl_in_ready",  in_ready,  !pending);
      if (ev) begin
        check("mdl_y",    y,    exp_y);
        check("mdl_hi",   hi,   exp_hi);
        check("mdl_zero", zero, (exp_y == '0));
      end
    end
  end

  // Issue one op, keep junk on the inputs while busy, check literals and latency.
  task automatic run_op(input string nm, input logic [W-1:0] av, bv, input logic [3:0] fv,
                        input logic [W-1:0] ey, ehi, input int lat, input int hold);
    int n;
    @(negedge clk);
    a = av; b = bv; f = fv; in_valid = 1'b1; out_ready = (hold == 0);
    check({nm, "_ready_before"}, in_ready, 1'b1);
    @(posedge clk);
    #1;
    a = $urandom; b = $urandom; f = 4'($urandom);
    @(negedge clk);
    n = 1;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, lat);
    check({nm, "_y"}, y, ey);
    check({nm, "_hi"}, hi, ehi);
    check({nm, "_zero"}, zero, (ey == '0));
    repeat (hold) begin
      @(negedge clk);
      check({nm, "_hold_y"}, y, ey);
      check({nm, "_hold_hi"}, hi, ehi);
      check({nm, "_hold_valid"}, out_valid, 1'b1);
      check({nm, "_hold_in_ready"}, in_ready, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check({nm, "_idle_in_ready"}, in_ready, 1'b1);
    check({nm, "_idle_out_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    run_op("add",      32'd5,          32'hFFFF_FFFD, OP_ADD,   32'd2,          32'd0, 1, 0);
    run_op("sub_eq",   32'd7,          32'd7,         OP_SUB,   32'd0,          32'd0, 1, 0);
    run_op("slt_neg",  32'hFFFF_FFFF,  32'd1,         OP_SLT,   32'd1,          32'd0, 1, 0);
    run_op("slt_pos",  32'd1,          32'hFFFF_FFFF, OP_SLT,   32'd0,          32'd0, 1, 0);
    run_op("and",      32'hF0F0_F0F0,  32'hFF00_FF00, OP_AND,   32'hF000_F000,  32'd0, 1, 0);
    run_op("or",       32'h0F00_00F0,  32'h0000_0001, OP_OR,    32'h0F00_00F1,  32'd0, 1, 0);
    run_op("rsv_3",    32'd5,          32'd3,         4'b0011,  32'd0,          32'd0, 1, 0);
    run_op("rsv_f",    32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'b1111,  32'd0,          32'd0, 1, 0);
    run_op("mul_x2",   32'hFFFF_FFFF,  32'd2,         OP_MULTU, 32'hFFFF_FFFE,  32'd1, W+1, 0);
    run_op("mul_max",  32'hFFFF_FFFF,  32'hFFFF_FFFF, OP_MULTU, 32'h0000_0001,  32'hFFFF_FFFE, W+1, 0);
    run_op("mul_hi",   32'h0001_0000,  32'h0001_0000, OP_MULTU, 32'd0,          32'd1, W+1, 0);
    run_op("div",      32'd100,        32'd7,         OP_DIVU,  32'd14,         32'd2, W+1, 0);
    run_op("div_zero", 32'd9,          32'd0,         OP_DIVU,  32'hFFFF_FFFF,  32'd9, W+1, 0);
    run_op("div_small",32'd5,          32'd9,         OP_DIVU,  32'd0,          32'd5, W+1, 0);
    run_op("div_msb",  32'h8000_0000,  32'd3,         OP_DIVU,  32'h2AAA_AAAA,  32'd2, W+1, 0);
    run_op("div_one",  32'hFFFF_FFFF,  32'd1,         OP_DIVU,  32'hFFFF_FFFF,  32'd0, W+1, 0);
    run_op("bp_div",   32'd100,        32'd7,         OP_DIVU,  32'd14,         32'd2, W+1, 5);
    run_op("bp_add",   32'd1,          32'd2,         OP_ADD,   32'd3,          32'd0, 1, 5);

    // Abort a multiply partway through with an asynchronous reset.
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; f = OP_MULTU; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready",  in_ready,  1'b1);
    check("abort_y",         y,         '0);
    check("abort_hi",        hi,        '0);
    check("abort_zero",      zero,      1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    run_op("mul_after_rst", 32'd3, 32'd5, OP_MULTU, 32'd15, 32'd0, W+1, 0);
    run_op("add_after_rst", 32'd10, 32'd20, OP_ADD, 32'd30, 32'd0, 1, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
